// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers. It uses shift-add multiplication and
// restoring division, one radix-2 step per cycle, followed by a single cycle that fixes the sign.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rs;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;

  // op[0]=0 selects the signed variants
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits turning into quotient bits}
  assign div_rs   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_rs >= {1'b0, opnd_q};
  assign div_next = div_ge ? {div_rs[WIDTH-1:0] - opnd_q, acc_q[WIDTH-2:0], 1'b1}
                           : {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          state_d    = RUN;
          count_d    = '0;
          is_div_d   = op[1];
          div_zero_d = (b == '0);
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          acc_d      = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          opnd_d     = op[1] ? b_mag : a_mag;
        end
      end
      RUN: begin
        acc_d   = is_div_q ? div_next : mul_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves the dividend in the remainder; only the quotient is forced
        if (is_div_q) begin
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = div_zero_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit. An arithmetic reference model with a cycle countdown
// is compared against busy/done/hi/lo on every cycle, and literal results pin the key cases.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam int LAT = 33;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  int           cnt = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;
  logic         exp_done = 1'b0;
  logic [63:0]  pend = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference result as {HI, LO}, computed with plain 64-bit arithmetic
  function automatic logic [63:0] model_calc(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle model: an accepted start completes after LAT edges, and the result lands with a done pulse
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt = 0; exp_hi = '0; exp_lo = '0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          {exp_hi, exp_lo} = pend;
          exp_done = 1'b1;
        end
      end else begin
        if (wr_hi) exp_hi = wdata;
        if (wr_lo) exp_lo = wdata;
        if (start) begin
          pend = model_calc(op, a, b);
          cnt = LAT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checkOutput("cyc_busy", {63'b0, busy}, {63'b0, cnt > 0});
      checkOutput("cyc_done", {63'b0, done}, {63'b0, exp_done});
      checkOutput("cyc_hi", {32'b0, hi}, {32'b0, exp_hi});
      checkOutput("cyc_lo", {32'b0, lo}, {32'b0, exp_lo});
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic waitDone(input string name);
    int i = 0;
    while (done !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    checkOutput({name, "_done_seen"}, {63'b0, done}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] m;
    logic [1:0]  o;
    logic [31:0] x, y;

    reset = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;

    m = model_calc(2'b00, 32'hFFFFFFFD, 32'd7);
    checkOutput("model_mult", m, 64'hFFFFFFFF_FFFFFFEB);
    m = model_calc(2'b11, 32'd100, 32'd7);
    checkOutput("model_divu", m, 64'h00000002_0000000E);
    m = model_calc(2'b10, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("model_div_min", m, 64'h00000000_80000000);
    m = model_calc(2'b10, 32'd5, 32'd0);
    checkOutput("model_div0", m, 64'h00000005_FFFFFFFF);

    #1;
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    checkOutput("rst_hi", {32'b0, hi}, 64'd0);
    checkOutput("rst_lo", {32'b0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7);
    waitDone("t1");
    checkOutput("t1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone("t2a");
    checkOutput("t2a_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    applyStimulus(2'b11, 32'd100, 32'd7);
    waitDone("t2b");
    checkOutput("t2b_hilo", {hi, lo}, 64'h00000002_0000000E);

    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2);
    waitDone("t3");
    checkOutput("t3_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    applyStimulus(2'b10, 32'd5, 32'd0);
    waitDone("t4a");
    checkOutput("t4a_hilo", {hi, lo}, 64'h00000005_FFFFFFFF);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
    waitDone("t4b");
    checkOutput("t4b_hilo", {hi, lo}, 64'h00000000_80000000);

    applyStimulus(2'b11, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3; wr_hi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    waitDone("t5");
    checkOutput("t5_hilo", {hi, lo}, 64'h00000002_0000000E);
    wr_lo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    wr_lo = 1'b0;
    checkOutput("t5_mtlo", {32'b0, lo}, 64'h0000ABCD);

    // A write in the same cycle as an accepted start is overwritten by the result
    wr_hi = 1'b1; wdata = 32'h5555;
    applyStimulus(2'b01, 32'd9, 32'd9);
    wr_hi = 1'b0;
    waitDone("wrstart");
    checkOutput("wrstart_hilo", {hi, lo}, 64'h00000000_00000051);

    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: x = 32'h80000000;
        3: y = 32'hFFFFFFFF;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) begin
        wr_hi = 1'($urandom); wr_lo = 1'($urandom); wdata = $urandom;
        @(negedge clk);
      end
      wr_hi = 1'b0; wr_lo = 1'b0;
      applyStimulus(o, x, y);
      waitDone("rand");
    end

    applyStimulus(2'b01, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_busy", {63'b0, busy}, 64'd0);
    checkOutput("t6_done", {63'b0, done}, 64'd0);
    checkOutput("t6_hi", {32'b0, hi}, 64'd0);
    checkOutput("t6_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b01, 32'd6, 32'd7);
    waitDone("t6");
    checkOutput("t6_hilo", {hi, lo}, 64'h00000000_0000002A);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
